// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one request in flight to a variable-latency instruction memory.
// A redirect never aborts that request: its data is discarded instead. A result
// that arrives while decode is stalled is parked in a one-entry skid buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_addr,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding, result will be used
    S_DROP  = 2'd1,  // request outstanding, result will be discarded
    S_HOLD  = 2'd2   // result parked in skid buffer, no request
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_req_addr, w_req_addr;
  logic [31:0] r_buf, w_buf;
  logic [31:0] r_buf_addr, w_buf_addr;
  logic [31:0] r_id_addr, w_id_addr;
  logic [31:0] r_id_inst, w_id_inst;
  logic        r_id_valid, w_id_valid;

  assign imem_req  = ((r_state == S_FETCH) || (r_state == S_DROP)) && !rst;
  assign imem_addr = r_req_addr;
  assign id_addr   = r_id_addr;
  assign id_inst   = r_id_inst;
  assign id_valid  = r_id_valid;

  // Next-state and next-IF/ID: stall beats redirect, redirect beats ack.
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_req_addr = r_req_addr;
    w_buf      = r_buf;
    w_buf_addr = r_buf_addr;
    w_id_addr  = r_id_addr;
    w_id_inst  = r_id_inst;
    w_id_valid = r_id_valid;
    case (r_state)
      S_FETCH: begin
        if (stall) begin
          if (imem_ack) begin
            w_buf      = imem_rdata;
            w_buf_addr = r_req_addr;
            w_state    = S_HOLD;
          end
        end else if (branch_valid) begin
          w_id_addr  = '0;
          w_id_inst  = NOP_INST;
          w_id_valid = 1'b0;
          w_pc       = branch_addr;
          if (imem_ack) w_req_addr = branch_addr;
          else          w_state    = S_DROP;
        end else if (imem_ack) begin
          w_id_addr  = r_req_addr;
          w_id_inst  = imem_rdata;
          w_id_valid = 1'b1;
          w_pc       = r_req_addr + 32'd4;
          w_req_addr = r_req_addr + 32'd4;
        end else begin
          w_id_addr  = '0;
          w_id_inst  = NOP_INST;
          w_id_valid = 1'b0;
        end
      end
      S_DROP: begin
        if (!stall) begin
          w_id_addr  = '0;
          w_id_inst  = NOP_INST;
          w_id_valid = 1'b0;
          if (branch_valid) w_pc = branch_addr;
        end
        // w_pc already carries a same-cycle redirect, so it is the next address.
        if (imem_ack) begin
          w_req_addr = w_pc;
          w_state    = S_FETCH;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          if (branch_valid) begin
            w_id_addr  = '0;
            w_id_inst  = NOP_INST;
            w_id_valid = 1'b0;
            w_pc       = branch_addr;
            w_req_addr = branch_addr;
          end else begin
            w_id_addr  = r_buf_addr;
            w_id_inst  = r_buf;
            w_id_valid = 1'b1;
            w_pc       = r_buf_addr + 32'd4;
            w_req_addr = r_buf_addr + 32'd4;
          end
          w_state = S_FETCH;
        end
      end
      default: w_state = S_FETCH;
    endcase
  end

  // State and pipeline registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_buf      <= '0;
      r_buf_addr <= '0;
      r_id_addr  <= '0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_req_addr <= w_req_addr;
      r_buf      <= w_buf;
      r_buf_addr <= w_buf_addr;
      r_id_addr  <= w_id_addr;
      r_id_inst  <= w_id_inst;
      r_id_valid <= w_id_valid;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural transaction model checked every cycle,
// directed scenarios with literal expectations, and a latency-controlled memory.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst, stall, branch_valid;
  logic [31:0] branch_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] id_addr, id_inst;
  logic        id_valid;

  int checks = 0;
  int failures = 0;

  if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_addr(id_addr),
    .id_inst(id_inst), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  // Memory: ack after 'lat' wait cycles of an outstanding request; forgets on rst.
  int unsigned lat = 0;
  int unsigned mem_cnt = 0;
  assign imem_ack   = imem_req && (mem_cnt >= lat);
  assign imem_rdata = imem_ack ? (imem_addr | 32'h13) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) mem_cnt <= 0;
    else                              mem_cnt <= mem_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one request may be in flight (m_busy); it is either
  // wanted or already superseded (m_stale); otherwise a parked result exists.
  bit          m_init = 0;
  bit          m_busy, m_stale;
  logic [31:0] m_next, m_inflight, m_park_addr, m_park_data;
  logic [31:0] m_id_addr, m_id_inst;
  logic        m_id_valid;

  task automatic m_bubble();
    m_id_addr = 32'h0; m_id_inst = 32'h13; m_id_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_busy = 1; m_stale = 0;
      m_next = 32'h0; m_inflight = 32'h0;
      m_bubble();
    end else if (m_init) begin
      if (!m_busy) begin
        if (!stall) begin
          if (branch_valid) begin
            m_bubble();
            m_next = branch_addr;
          end else begin
            m_id_addr = m_park_addr; m_id_inst = m_park_data; m_id_valid = 1'b1;
            m_next = m_park_addr + 32'd4;
          end
          m_inflight = m_next; m_busy = 1; m_stale = 0;
        end
      end else if (m_stale) begin
        if (!stall) begin
          m_bubble();
          if (branch_valid) m_next = branch_addr;
        end
        if (imem_ack) begin m_inflight = m_next; m_stale = 0; end
      end else if (stall) begin
        if (imem_ack) begin
          m_park_addr = m_inflight; m_park_data = imem_rdata; m_busy = 0;
        end
      end else if (branch_valid) begin
        m_bubble();
        m_next = branch_addr;
        if (imem_ack) m_inflight = branch_addr;
        else          m_stale = 1;
      end else if (imem_ack) begin
        m_id_addr = m_inflight; m_id_inst = imem_rdata; m_id_valid = 1'b1;
        m_next = m_inflight + 32'd4;
        m_inflight = m_next;
      end else begin
        m_bubble();
      end
    end
  end

  // Per-cycle comparison against the model, after the edge settles.
  always @(posedge clk) begin
    #2;
    if (m_init) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy && !rst});
      if (m_busy && !rst) chk("imem_addr", imem_addr, m_inflight);
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
      chk("id_addr", id_addr, m_id_addr);
      chk("id_inst", id_inst, m_id_inst);
    end
  end

  task automatic cyc();
    @(posedge clk); #3;
  endtask

  initial begin
    logic [39:0] st_pat;
    logic [39:0] bv_pat;
    st_pat = 40'h30_0C06_1800;
    bv_pat = 40'h06_4120_8249;
    rst = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_addr = 32'h0;
    lat = 0;
    cyc(); cyc();
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_inst", id_inst, 32'h13);
    chk("rst_id_addr", id_addr, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);

    // 0-latency streaming
    rst = 1'b0;
    cyc();
    chk("s1_addr4", imem_addr, 32'h4);
    chk("s1_id0", id_addr, 32'h0);
    chk("s1_valid", {31'b0, id_valid}, 32'h1);
    cyc();
    chk("s1_addr8", imem_addr, 32'h8);
    chk("s1_id4", id_addr, 32'h4);
    chk("s1_inst4", id_inst, 32'h17);

    // stall while 0x8 is acked: parked, then released
    stall = 1'b1;
    cyc();
    chk("s3_hold_id", id_addr, 32'h4);
    chk("s3_req0", {31'b0, imem_req}, 32'h0);
    cyc();
    chk("s3_hold_id2", id_addr, 32'h4);
    stall = 1'b0;
    cyc();
    chk("s3_rel_id", id_addr, 32'h8);
    chk("s3_rel_inst", id_inst, 32'h1b);
    chk("s3_next_addr", imem_addr, 32'hC);

    // stall and redirect together: redirect ignored
    stall = 1'b1; branch_valid = 1'b1; branch_addr = 32'h200;
    cyc();
    chk("s5_id_same", id_addr, 32'h8);
    stall = 1'b0; branch_valid = 1'b0;
    cyc();
    chk("s5_id_c", id_addr, 32'hC);
    chk("s5_no_redirect", imem_addr, 32'h10);

    // redirect while 0x10 pending, ack two cycles later
    lat = 2;
    branch_valid = 1'b1; branch_addr = 32'h100;
    cyc();
    chk("s4_bubble", {31'b0, id_valid}, 32'h0);
    chk("s4_addr_stable", imem_addr, 32'h10);
    branch_valid = 1'b0;
    cyc(); cyc();
    chk("s4_target", imem_addr, 32'h100);
    cyc(); cyc(); cyc();
    chk("s4_first_tgt", id_addr, 32'h100);
    chk("s4_first_inst", id_inst, 32'h113);

    // 3-cycle latency: bubbles between instructions
    lat = 3;
    cyc();
    chk("s2_bubble_inst", id_inst, 32'h13);
    chk("s2_held", imem_addr, 32'h104);
    cyc(); cyc();
    chk("s2_bubble_v", {31'b0, id_valid}, 32'h0);
    cyc();
    chk("s2_next", id_addr, 32'h104);

    // reset while a discarded request is outstanding
    branch_valid = 1'b1; branch_addr = 32'h300;
    cyc();
    branch_valid = 1'b0; rst = 1'b1;
    cyc();
    chk("s6_valid", {31'b0, id_valid}, 32'h0);
    chk("s6_inst", id_inst, 32'h13);
    rst = 1'b0;
    cyc();
    chk("s6_reset_pc", imem_addr, 32'h0);
    lat = 0;
    cyc(); cyc();
    chk("s6_restart", id_addr, 32'h4);

    // address wrap at the top of memory
    branch_valid = 1'b1; branch_addr = 32'hFFFF_FFFC;
    cyc();
    branch_valid = 1'b0;
    cyc();
    chk("wrap_inst", id_inst, 32'hFFFF_FFFF);
    chk("wrap_addr", imem_addr, 32'h0);

    // mixed stall/redirect/latency sequence, checked by the model
    for (int i = 0; i < 40; i++) begin
      lat          = (i / 8) % 3;
      stall        = st_pat[i];
      branch_valid = bv_pat[i];
      branch_addr  = 32'h400 + 32'(i) * 32'd16;
      cyc();
    end
    stall = 1'b0; branch_valid = 1'b0; lat = 1;
    repeat (8) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
